// File: rtl/alu_pkg.sv
// ALU operation codes, op legality check and controller FSM encoding
// shared by the ALU-sharing controller and its clients.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } ctrlStateT;

   // True for op codes the ALU implements; anything else is reported as an error.
   function automatic logic opLegal(input logic [3:0] op);
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: opLegal = 1'b1;
         default:                                             opLegal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after
// the pointer wins, wrapping to the lowest requesting index overall.
module rr_arbiter
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
)
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grantIdx,
   output logic             anyReq
);

   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   logic [N_REQ-1:0]            geMask;
   logic [N_REQ-1:0]            reqHi;
   logic [N_REQ-1:0]            pick;
   logic [IDX_W-1:0][N_REQ-1:0] idxMask;

   // geMask selects requesters at or after the pointer; idxMask[b] marks
   // the requester numbers whose binary index has bit b set.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : gMask
      assign geMask[gi] = (gi >= int'(ptr));
      for (genvar gb = 0; gb < IDX_W; gb++) begin : gBit
         assign idxMask[gb][gi] = ((gi >> gb) & 1) != 0;
      end
   end

   // Prefer requests at/after the pointer, otherwise wrap; isolate lowest set bit.
   assign reqHi  = req & geMask;
   assign pick   = (|reqHi) ? reqHi : req;
   assign grant  = pick & ~(pick - ONE);
   assign anyReq = |req;

   // One-hot grant to binary index.
   for (genvar gb = 0; gb < IDX_W; gb++) begin : gIdx
      assign grantIdx[gb] = |(grant & idxMask[gb]);
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between N_REQ requesters: round-robin grant,
// registered operands, one ALU cycle, registered result held until consumed.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REQ = 2
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [4*N_REQ-1:0] req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_zero,
   output logic               rsp_err,
   output logic [3:0]         alu_sel,
   output logic [WIDTH-1:0]   alu_in1,
   output logic [WIDTH-1:0]   alu_in2,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_zero
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   ctrlStateT        stateReg;
   logic [IDX_W-1:0] ptrReg;
   logic [IDX_W-1:0] grantIdxReg;
   logic [3:0]       opReg;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [N_REQ-1:0] rspValidReg;
   logic [WIDTH-1:0] rspDataReg;
   logic             rspZeroReg;
   logic             rspErrReg;
   logic             rstMeta;
   logic             rstSyncN;

   logic [N_REQ-1:0] arbGrant;
   logic [IDX_W-1:0] arbIdx;
   logic             arbAny;
   logic             accept;

   logic [3:0]       opArr [N_REQ];
   logic [WIDTH-1:0] aArr  [N_REQ];
   logic [WIDTH-1:0] bArr  [N_REQ];

   // Per-requester views of the packed request buses.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : gSlice
      assign opArr[gi] = req_op[4*gi +: 4];
      assign aArr[gi]  = req_a[WIDTH*gi +: WIDTH];
      assign bArr[gi]  = req_b[WIDTH*gi +: WIDTH];
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) uArb (
      .req      (req_valid),
      .ptr      (ptrReg),
      .grant    (arbGrant),
      .grantIdx (arbIdx),
      .anyReq   (arbAny)
   );

   // Reset asserts immediately but releases two clocks later, synchronously;
   // no request is accepted until the release has propagated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstMeta  <= 1'b0;
         rstSyncN <= 1'b0;
      end else begin
         rstMeta  <= 1'b1;
         rstSyncN <= rstMeta;
      end
   end

   assign accept    = (stateReg == IDLE) && arbAny && rstSyncN;
   assign req_ready = accept ? arbGrant : '0;

   // The ALU sees the latched operands only while executing, zeros otherwise.
   assign alu_sel = (stateReg == EXEC) ? opReg : 4'd0;
   assign alu_in1 = (stateReg == EXEC) ? aReg  : '0;
   assign alu_in2 = (stateReg == EXEC) ? bReg  : '0;

   assign rsp_valid = rspValidReg;
   assign rsp_data  = rspDataReg;
   assign rsp_zero  = rspZeroReg;
   assign rsp_err   = rspErrReg;

   // Transaction FSM: accept and latch, run the ALU for one cycle, hold the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg    <= IDLE;
         ptrReg      <= '0;
         grantIdxReg <= '0;
         opReg       <= 4'd0;
         aReg        <= '0;
         bReg        <= '0;
         rspValidReg <= '0;
         rspDataReg  <= '0;
         rspZeroReg  <= 1'b0;
         rspErrReg   <= 1'b0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (accept) begin
                  grantIdxReg <= arbIdx;
                  opReg       <= opArr[arbIdx];
                  aReg        <= aArr[arbIdx];
                  bReg        <= bArr[arbIdx];
                  ptrReg      <= (arbIdx == LAST_IDX) ? '0 : arbIdx + 1'b1;
                  stateReg    <= EXEC;
               end
            end
            EXEC: begin
               // Illegal ops report a zero result regardless of what the ALU returns.
               if (opLegal(opReg)) begin
                  rspDataReg <= alu_out;
                  rspZeroReg <= alu_zero;
               end else begin
                  rspDataReg <= '0;
                  rspZeroReg <= 1'b1;
               end
               rspErrReg   <= !opLegal(opReg);
               rspValidReg <= ONE_HOT0 << grantIdxReg;
               stateReg    <= RESP;
            end
            RESP: begin
               if (rsp_ready[grantIdxReg]) begin
                  rspValidReg <= '0;
                  stateReg    <= IDLE;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the shared ALU.
module tb_alu_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_zero;
   logic        rsp_err;
   logic [3:0]  alu_sel;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_out;
   logic        alu_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          r;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expD;
      logic        expZ;
      logic        expE;
   } vecT;

   vecT vec [10];

   alu_share_ctrl #(.WIDTH(32), .N_REQ(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .alu_sel   (alu_sel),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero)
   );

   always #5 clk = ~clk;

   // Shared ALU: unsupported selects return 0.
   always_comb begin
      alu_out = 32'd0;
      case (alu_sel)
         4'd0:  alu_out = alu_in1 & alu_in2;
         4'd1:  alu_out = alu_in1 | alu_in2;
         4'd2:  alu_out = alu_in1 + alu_in2;
         4'd6:  alu_out = alu_in1 - alu_in2;
         4'd7:  alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
         4'd12: alu_out = ~(alu_in1 | alu_in2);
         default: alu_out = 32'd0;
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] oneHot(input int r);
      logic [1:0] m;
      m = 2'(1 << r);
      return m;
   endfunction

   task automatic setReq(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*r +: 4]  = op;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_valid         = req_valid | oneHot(r);
   endtask

   task automatic waitReady(input int r, input string name);
      int n = 0;
      while ((req_ready & oneHot(r)) == 2'b00 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_ready"}, 64'(req_ready), 64'(oneHot(r)));
   endtask

   task automatic chkAllZero(input string name);
      chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({name, "_rsp_data"},  64'(rsp_data),  64'd0);
      chk({name, "_rsp_zero"},  64'(rsp_zero),  64'd0);
      chk({name, "_rsp_err"},   64'(rsp_err),   64'd0);
      chk({name, "_alu_sel"},   64'(alu_sel),   64'd0);
      chk({name, "_alu_in1"},   64'(alu_in1),   64'd0);
      chk({name, "_alu_in2"},   64'(alu_in2),   64'd0);
   endtask

   // One full transaction: accept, check EXEC-cycle ALU drive, response at +2, handshake.
   task automatic runTxn(input vecT v, input string name);
      @(negedge clk);
      setReq(v.r, v.op, v.a, v.b);
      #1;
      waitReady(v.r, name);
      @(negedge clk);
      req_valid = req_valid & ~oneHot(v.r);
      #1;
      chk({name, "_exec_valid"}, 64'(rsp_valid), 64'd0);
      chk({name, "_alu_sel"},    64'(alu_sel),   64'(v.op));
      chk({name, "_alu_in1"},    64'(alu_in1),   64'(v.a));
      chk({name, "_alu_in2"},    64'(alu_in2),   64'(v.b));
      @(negedge clk);
      #1;
      chk({name, "_rsp_valid"},  64'(rsp_valid), 64'(oneHot(v.r)));
      chk({name, "_rsp_data"},   64'(rsp_data),  64'(v.expD));
      chk({name, "_rsp_zero"},   64'(rsp_zero),  64'(v.expZ));
      chk({name, "_rsp_err"},    64'(rsp_err),   64'(v.expE));
      rsp_ready = oneHot(v.r);
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      chk({name, "_done"},       64'(rsp_valid), 64'd0);
      $display("txn %s req%0d op=%0d a=0x%0h b=0x%0h -> data=0x%0h zero=%0d err=%0d",
               name, v.r, v.op, v.a, v.b, rsp_data, rsp_zero, rsp_err);
   endtask

   initial begin
      vec[0] = '{0, 4'd2,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
      vec[1] = '{1, 4'd6,  32'h10,       32'h10,       32'd0,        1'b1, 1'b0};
      vec[2] = '{0, 4'd0,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0};
      vec[3] = '{1, 4'd1,  32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0, 1'b0};
      vec[4] = '{0, 4'd7,  32'd3,        32'd5,        32'd1,        1'b0, 1'b0};
      vec[5] = '{1, 4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
      vec[6] = '{0, 4'd12, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
      vec[7] = '{1, 4'd3,  32'd1,        32'd1,        32'd0,        1'b1, 1'b1};
      vec[8] = '{0, 4'd2,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
      vec[9] = '{1, 4'd6,  32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b0};

      rst_n     = 1'b0;
      req_valid = 2'b01;
      req_op    = 8'h02;
      req_a     = 64'd0;
      req_b     = 64'd0;
      rsp_ready = 2'b00;

      // Outputs held at zero in reset even with a request pending.
      repeat (3) @(negedge clk);
      #1;
      chkAllZero("reset");
      req_valid = 2'b00;
      rst_n     = 1'b1;
      repeat (4) @(negedge clk);
      $display("reset released");

      // Table-driven single transactions, including the illegal op followed by legal ones.
      for (int i = 0; i < 10; i++) begin
         runTxn(vec[i], $sformatf("vec%0d", i));
      end

      // Backpressure: response held while rsp_ready is low; a waiting requester is stalled.
      @(negedge clk);
      setReq(0, 4'd2, 32'd100, 32'd23);
      #1;
      waitReady(0, "bp");
      @(negedge clk);
      req_valid = 2'b00;
      setReq(1, 4'd1, 32'd3, 32'd4);
      #1;
      chk("bp_exec_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("bp_first_valid", 64'(rsp_valid), 64'h1);
      for (int i = 0; i < 5; i++) begin
         rsp_ready = (i == 2) ? 2'b10 : 2'b00;
         @(negedge clk);
         #1;
         chk($sformatf("bp_hold%0d_valid", i), 64'(rsp_valid), 64'h1);
         chk($sformatf("bp_hold%0d_data", i),  64'(rsp_data),  64'd123);
         chk($sformatf("bp_hold%0d_ready", i), 64'(req_ready), 64'd0);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      chk("bp_released_valid", 64'(rsp_valid), 64'd0);
      chk("bp_stalled_grant",  64'(req_ready), 64'h2);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      chk("bp_req1_valid", 64'(rsp_valid), 64'h2);
      chk("bp_req1_data",  64'(rsp_data),  64'd7);
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;
      $display("txn backpressure done");

      // Reset while executing a request from requester 0 (pointer would move to 1).
      @(negedge clk);
      setReq(0, 4'd2, 32'd9, 32'd9);
      #1;
      waitReady(0, "rstx");
      @(negedge clk);
      #1;
      chk("rstx_exec_sel", 64'(alu_sel), 64'd2);
      rst_n = 1'b0;
      #1;
      chkAllZero("rstx");
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rstx_norsp%0d", i), 64'(rsp_valid), 64'd0);
      end
      $display("txn reset-in-exec done");

      // Contention from pointer 0: grants must alternate 0,1,0,1 with one-hot responses.
      @(negedge clk);
      setReq(0, 4'd2, 32'd1,  32'd1);
      setReq(1, 4'd2, 32'd10, 32'd10);
      rsp_ready = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         int r;
         logic [31:0] expD;
         r    = k % 2;
         expD = (r == 0) ? 32'd2 : 32'd20;
         waitReady(r, $sformatf("cont%0d", k));
         @(negedge clk);
         #1;
         @(negedge clk);
         #1;
         chk($sformatf("cont%0d_valid", k),  64'(rsp_valid),          64'(oneHot(r)));
         chk($sformatf("cont%0d_onehot", k), 64'($onehot(rsp_valid)), 64'd1);
         chk($sformatf("cont%0d_data", k),   64'(rsp_data),           64'(expD));
         $display("txn contention %0d grant=req%0d data=0x%0h", k, r, rsp_data);
      end
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      #1;
      chk("cont_end_valid", 64'(rsp_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
